// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: 2-entry sample-pair FIFO feeding a 64-BCLK frame serialiser.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   in_valid/in_ready     sample-pair handshake (in_ready = FIFO not full)
//   in_l, in_r            signed 16-bit left/right samples
//   mute                  sampled at frame load; forces the loaded frame's words to zero
//   i2s_bclk              bit clock, half-period of BCLK_DIV clk cycles
//   i2s_lrclk             word select (0 = left half, 1 = right half)
//   i2s_sdata             serial data, MSB first, changes on BCLK falling edges
//   frame_start           1-clk pulse in the frame load cycle
//   underrun              1-clk pulse when a frame is loaded with the FIFO empty
//
// Configuration
//   I2S_TX_LEFT_JUSTIFIED_EN  defined: left-justified slot mapping (MSB on the lrclk edge);
//                             undefined: standard I2S (MSB one BCLK after the lrclk edge).

package audio_i2s_tx_pkg;
    localparam int unsigned SAMPLE_W = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } sample_pair_t;
endpackage

module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_l,
    input  logic [SAMPLE_W-1:0] in_r,
    input  logic                mute,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned BIT_W      = 6;
    localparam int unsigned SLOT_W     = 5;
    localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    // Bit value for slot position s of a channel word.
    function automatic logic slot_bit(input logic [SLOT_W-1:0] s, input logic [SAMPLE_W-1:0] w);
        logic b;
        b = 1'b0;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        if (s <= SLOT_W'(15)) begin
            b = w[4'(SLOT_W'(15) - s)];
        end
`else
        if ((s >= SLOT_W'(1)) && (s <= SLOT_W'(16))) begin
            b = w[4'(SLOT_W'(16) - s)];
        end
`endif
        return b;
    endfunction

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_next;
    logic                div_tick;
    logic                bclk_fall;
    logic                frame_load;

    sample_pair_t        fifo_mem [FIFO_DEPTH];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W-1:0]    fifo_cnt_next;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    sample_pair_t        held;
    sample_pair_t        held_next;
    logic                muted;
    logic                muted_next;
    logic [SAMPLE_W-1:0] tx_word;
    logic                tx_bit;

    // Bit clock divider and frame timing strobes
    assign div_tick   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_fall  = div_tick && i2s_bclk;
    assign bit_next   = bit_cnt + BIT_W'(1);
    assign frame_load = bclk_fall && (bit_cnt == BIT_W'(63));

    // FIFO control
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = in_valid && in_ready;
    assign pop        = frame_load && !fifo_empty;

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_next = fifo_cnt + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_next = fifo_cnt - CNT_W'(1);
        end
    end

    // Held frame: replaced on load when data is available, otherwise repeated
    always_comb begin
        held_next  = held;
        muted_next = muted;
        if (frame_load) begin
            muted_next = mute;
            if (!fifo_empty) begin
                held_next = fifo_mem[rd_ptr];
            end
        end
    end

    // Bit for the slot that begins on this falling edge; uses the freshly loaded frame on a load
    always_comb begin
        tx_word = bit_next[BIT_W-1] ? held_next.r : held_next.l;
        if (muted_next) begin
            tx_word = '0;
        end
        tx_bit = slot_bit(bit_next[SLOT_W-1:0], tx_word);
    end

    // Control, timing and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            i2s_bclk    <= 1'b0;
            bit_cnt     <= '0;
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            held        <= '0;
            muted       <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
            in_ready    <= 1'b1;
        end else begin
            frame_start <= frame_load;
            underrun    <= frame_load && fifo_empty;

            if (div_tick) begin
                div_cnt  <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end

            if (bclk_fall) begin
                bit_cnt   <= bit_next;
                i2s_lrclk <= bit_next[BIT_W-1];
                i2s_sdata <= tx_bit;
            end

            held  <= held_next;
            muted <= muted_next;

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt_next;
            in_ready <= (fifo_cnt_next != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr].l <= in_l;
            fifo_mem[wr_ptr].r <= in_r;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Testbench for audio_i2s_tx (BCLK_DIV = 2). Stimulus pushes expected frames into a queue;
// an independent monitor reassembles frames from the serial lines and compares them.
module tb_audio_i2s_tx;

    localparam int unsigned BCLK_DIV   = 2;
    localparam int unsigned FRAME_CLKS = 128 * BCLK_DIV;

    typedef struct packed {
        logic [63:0] bits;
        logic        ur;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        mute = 1'b0;
    logic        in_ready;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_start;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_i2s_tx #(.BCLK_DIV(BCLK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_l        (in_l),
        .in_r        (in_r),
        .mute        (mute),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slot-indexed frame image: bit i is the value on sdata during BCLK slot i.
    function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        logic [15:0] w;
        int s;
        f = '0;
        for (int i = 0; i < 64; i++) begin
            w = (i < 32) ? l : r;
            s = i % 32;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            if (s <= 15) f[i] = w[15 - s];
`else
            if (s >= 1 && s <= 16) f[i] = w[16 - s];
`endif
        end
        return f;
    endfunction

    task automatic expect_frame(input logic [15:0] l, input logic [15:0] r, input logic ur);
        exp_t e;
        e.bits = mk_frame(l, r);
        e.ur   = ur;
        exp_q.push_back(e);
    endtask

    // Returns one cycle after a load edge (frame_start visible).
    task automatic wait_load();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!frame_start && n < 2 * FRAME_CLKS);
        check("load_seen", 64'(frame_start), 64'd1);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r, output int waited);
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 2 * int'(FRAME_CLKS)) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("push_accepted", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: rebuilds frames from bclk rising-edge samples and scores them
    initial begin
        int          idx;
        int          bclk_cnt;
        int          frame_cnt;
        bit          bclk_seen;
        bit          frame_seen;
        logic        prev_bclk;
        logic        lr_ok;
        logic        ur_seen;
        logic [63:0] cap;
        exp_t        e;
        idx = 0; bclk_cnt = 0; frame_cnt = 0; bclk_seen = 0; frame_seen = 0;
        prev_bclk = 1'b0; lr_ok = 1'b1; ur_seen = 1'b0; cap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                idx = 0; bclk_cnt = 0; frame_cnt = 0; bclk_seen = 0; frame_seen = 0;
                prev_bclk = 1'b0; lr_ok = 1'b1; ur_seen = 1'b0;
            end else begin
                bclk_cnt++;
                frame_cnt++;
                if (underrun) check("underrun_only_at_load", 64'(frame_start), 64'd1);
                if (frame_start) begin
                    if (frame_seen) check("frame_period", 64'(frame_cnt), 64'(FRAME_CLKS));
                    check("frame_boundary", 64'(idx), 64'd64);
                    frame_seen = 1; frame_cnt = 0; idx = 0; lr_ok = 1'b1; ur_seen = underrun;
                end
                if (i2s_bclk != prev_bclk) begin
                    if (bclk_seen) check("bclk_half_period", 64'(bclk_cnt), 64'(BCLK_DIV));
                    bclk_seen = 1; bclk_cnt = 0;
                    if (i2s_bclk && idx < 64) begin
                        cap[idx] = i2s_sdata;
                        if (i2s_lrclk != (idx >= 32)) lr_ok = 1'b0;
                        idx++;
                        if (idx == 64) begin
                            check("lrclk_slots", 64'(lr_ok), 64'd1);
                            check("expected_frame_queued", 64'(exp_q.size() != 0), 64'd1);
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                check("frame_data", cap, e.bits);
                                check("frame_underrun", 64'(ur_seen), 64'(e.ur));
                            end
                        end
                    end
                end
                prev_bclk = i2s_bclk;
            end
        end
    end

    // Stimulus
    initial begin
        int w;
        int c0;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, in_ready}),
              64'(6'b000001));
        reset = 1'b0;
        expect_frame(16'h0000, 16'h0000, 1'b0);

        // Idle: zero frames with underrun at every load
        wait_load(); expect_frame(16'h0000, 16'h0000, 1'b1);
        wait_load(); expect_frame(16'h0000, 16'h0000, 1'b1);

        // Single pair, extreme bit patterns
        push_pair(16'h8001, 16'h7FFE, w);
        wait_load(); expect_frame(16'h8001, 16'h7FFE, 1'b0);

        // Three back-to-back pairs: the third waits for the next load
        push_pair(16'h0F0F, 16'hF0F0, w);
        push_pair(16'h8000, 16'h0001, w);
        check("in_ready_full", 64'(in_ready), 64'd0);
        push_pair(16'hFFFF, 16'h5555, w);
        check("third_push_waited", 64'(w > 0), 64'd1);
        expect_frame(16'h0F0F, 16'hF0F0, 1'b0);
        wait_load(); expect_frame(16'h8000, 16'h0001, 1'b0);
        wait_load(); expect_frame(16'hFFFF, 16'h5555, 1'b0);

        // Mute consumes the pair; next load with empty FIFO repeats it
        push_pair(16'h1234, 16'h5678, w);
        mute = 1'b1;
        wait_load(); expect_frame(16'h0000, 16'h0000, 1'b0);
        mute = 1'b0;
        wait_load(); expect_frame(16'h1234, 16'h5678, 1'b1);

        // Fill FIFO, load one, refill, then reset in the right slot
        push_pair(16'h1111, 16'h2222, w);
        push_pair(16'h3333, 16'h4444, w);
        check("in_ready_full_b", 64'(in_ready), 64'd0);
        wait_load(); expect_frame(16'h1111, 16'h2222, 1'b0);
        c0 = cyc;
        push_pair(16'h6666, 16'h7777, w);
        check("in_ready_full_c", 64'(in_ready), 64'd0);
        while (cyc < c0 + 161) begin
            @(posedge clk); #1;
        end
        check("lrclk_right_before_reset", 64'(i2s_lrclk), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midframe_reset_outputs",
              64'({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, in_ready}), 64'(6'b000001));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_frame(16'h0000, 16'h0000, 1'b0);

        // After reset: FIFO flushed, new pair then repeat
        push_pair(16'hC3C3, 16'h3C3C, w);
        wait_load(); expect_frame(16'hC3C3, 16'h3C3C, 1'b0);
        wait_load(); expect_frame(16'hC3C3, 16'h3C3C, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 2 * int'(FRAME_CLKS)) begin
            @(posedge clk);
            n++;
        end
        check("all_frames_seen", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
